// File: rtl/mesi_isc_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mesi_isc_mon_pkg
// Purpose  : Shared definitions for the MESI ISC coherence monitor: the cache
//            line state encodings (identical to MESI_ISC_TB_CPU_MESI_*), the
//            bit positions of the violation class vector and the monitor FSM
//            state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mesi_isc_mon_pkg;

   localparam logic [3:0] c_mesi_m = 4'b1001;
   localparam logic [3:0] c_mesi_e = 4'b0101;
   localparam logic [3:0] c_mesi_s = 4'b0011;
   localparam logic [3:0] c_mesi_i = 4'b0000;

   // Bit positions inside viol_type / first_type
   localparam int VT_MULTI_M    = 0;
   localparam int VT_M_SHARED   = 1;
   localparam int VT_E_CONFLICT = 2;
   localparam int VT_ILLEGAL    = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHECK   = 2'd1,
      ST_PENDING = 2'd2,
      ST_FLAGGED = 2'd3
   } mon_state_e;

endpackage
`default_nettype wire

// File: rtl/mesi_isc_mon_classify.sv
`default_nettype none
// ============================================================================
// Module   : mesi_isc_mon_classify
// Purpose  : Combinational classification of one sampled global state vector.
// Ports    : i_samp      - packed cache states, CPU i at [i*STATE_W +: STATE_W]
//            o_m_mask    - CPUs in M        o_e_mask    - CPUs in E
//            o_s_mask    - CPUs in S        o_noni_mask - CPUs not in I
//            o_class     - violation classes (VT_* bit positions)
//            o_one_m     - exactly one CPU in M
//            o_m_owner   - lowest-index CPU in M (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module mesi_isc_mon_classify
   import mesi_isc_mon_pkg::*;
#(
   parameter int NUM_CPU = 4,
   parameter int STATE_W = 4
) (
   input  logic [NUM_CPU*STATE_W-1:0]  i_samp,
   output logic [NUM_CPU-1:0]          o_m_mask,
   output logic [NUM_CPU-1:0]          o_e_mask,
   output logic [NUM_CPU-1:0]          o_s_mask,
   output logic [NUM_CPU-1:0]          o_noni_mask,
   output logic [3:0]                  o_class,
   output logic                        o_one_m,
   output logic [$clog2(NUM_CPU)-1:0]  o_m_owner
);

   localparam int OWN_W = $clog2(NUM_CPU);
   localparam logic [NUM_CPU-1:0] c_one = NUM_CPU'(1);

   logic [NUM_CPU-1:0] w_i_mask;
   logic [NUM_CPU-1:0] w_ill_mask;
   logic [NUM_CPU-1:0] w_legal_noni;
   logic               w_multi_m;
   logic               w_multi_e;

   for (genvar gi = 0; gi < NUM_CPU; gi++) begin : g_cpu
      logic [STATE_W-1:0] w_field;
      assign w_field        = i_samp[gi*STATE_W +: STATE_W];
      assign o_m_mask[gi]   = (w_field == STATE_W'(c_mesi_m));
      assign o_e_mask[gi]   = (w_field == STATE_W'(c_mesi_e));
      assign o_s_mask[gi]   = (w_field == STATE_W'(c_mesi_s));
      assign w_i_mask[gi]   = (w_field == STATE_W'(c_mesi_i));
   end

   assign w_ill_mask   = ~(o_m_mask | o_e_mask | o_s_mask | w_i_mask);
   // Illegal encodings count as "present" for the capture mask but are kept
   // out of the M/E/S checks so one corrupt field yields only ILLEGAL.
   assign o_noni_mask  = ~w_i_mask;
   assign w_legal_noni = o_m_mask | o_e_mask | o_s_mask;

   // x & (x-1) clears the lowest set bit: non-zero means two or more set.
   assign w_multi_m = |(o_m_mask & (o_m_mask - c_one));
   assign w_multi_e = |(o_e_mask & (o_e_mask - c_one));
   assign o_one_m   = (|o_m_mask) && !w_multi_m;

   always_comb begin
      o_class                = '0;
      o_class[VT_MULTI_M]    = w_multi_m;
      o_class[VT_M_SHARED]   = o_one_m && |(w_legal_noni & ~o_m_mask);
      o_class[VT_E_CONFLICT] = w_multi_e || (|o_e_mask && |o_s_mask);
      o_class[VT_ILLEGAL]    = |w_ill_mask;
   end

   // Scan downwards so the lowest-index M wins.
   always_comb begin
      o_m_owner = '0;
      for (int i = NUM_CPU - 1; i >= 0; i--) begin
         if (o_m_mask[i]) o_m_owner = OWN_W'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mesi_isc_coherence_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mesi_isc_coherence_monitor
// Purpose  : Samples every CPU's cache-line state each cycle, classifies
//            global MESI violations, debounces them over SETTLE_CYC extra
//            samples and reports pulse / sticky / saturating count / first
//            failure capture. Intended to be bound into mesi_isc_tb.
// Ports    : clk, rst (async, active low), enable, clr (sync clear),
//            cache_state (packed per-CPU states), violation (pulse),
//            viol_type (live class), err_sticky, viol_cnt, first_valid,
//            first_type, first_cpus, m_owner, m_owner_valid
// Revision : 1.0 - initial release
// ============================================================================
module mesi_isc_coherence_monitor
   import mesi_isc_mon_pkg::*;
#(
   parameter int NUM_CPU    = 4,
   parameter int STATE_W    = 4,
   parameter int SETTLE_CYC = 0,
   parameter int CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        clr,
   input  logic [NUM_CPU*STATE_W-1:0]  cache_state,
   output logic                        violation,
   output logic [3:0]                  viol_type,
   output logic                        err_sticky,
   output logic [CNT_W-1:0]            viol_cnt,
   output logic                        first_valid,
   output logic [3:0]                  first_type,
   output logic [NUM_CPU-1:0]          first_cpus,
   output logic [$clog2(NUM_CPU)-1:0]  m_owner,
   output logic                        m_owner_valid
);

   logic [NUM_CPU*STATE_W-1:0] r_samp;
   mon_state_e                 r_state;
   logic [7:0]                 r_settle;

   logic [NUM_CPU-1:0]         w_m_mask;
   logic [NUM_CPU-1:0]         w_e_mask;
   logic [NUM_CPU-1:0]         w_s_mask;
   logic [NUM_CPU-1:0]         w_noni_mask;
   logic [3:0]                 w_class;
   logic                       w_one_m;
   logic [$clog2(NUM_CPU)-1:0] w_m_owner;
   logic                       w_bad;
   logic                       w_flag;
   logic                       w_unused_masks;

   mesi_isc_mon_classify #(
      .NUM_CPU (NUM_CPU),
      .STATE_W (STATE_W)
   ) u_classify (
      .i_samp      (r_samp),
      .o_m_mask    (w_m_mask),
      .o_e_mask    (w_e_mask),
      .o_s_mask    (w_s_mask),
      .o_noni_mask (w_noni_mask),
      .o_class     (w_class),
      .o_one_m     (w_one_m),
      .o_m_owner   (w_m_owner)
   );

   assign w_unused_masks = ^{w_m_mask, w_e_mask, w_s_mask};
   assign w_bad          = |w_class;

   // Entry into FLAGGED this cycle. PENDING counts violating samples from 1;
   // the sample that finds the counter already at SETTLE_CYC is the
   // (SETTLE_CYC+1)-th consecutive one and triggers the flag.
   assign w_flag = enable && w_bad &&
                   (((r_state == ST_CHECK)   && (SETTLE_CYC == 0)) ||
                    ((r_state == ST_PENDING) && (r_settle == 8'(SETTLE_CYC))));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_samp        <= '0;
         r_state       <= ST_IDLE;
         r_settle      <= '0;
         violation     <= 1'b0;
         viol_type     <= '0;
         err_sticky    <= 1'b0;
         viol_cnt      <= '0;
         first_valid   <= 1'b0;
         first_type    <= '0;
         first_cpus    <= '0;
         m_owner       <= '0;
         m_owner_valid <= 1'b0;
      end else begin
         r_samp        <= cache_state;
         viol_type     <= w_class;
         m_owner       <= w_m_owner;
         m_owner_valid <= w_one_m && !w_bad;
         violation     <= w_flag;

         if (!enable) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state  <= ST_CHECK;
                  r_settle <= '0;
               end
               ST_CHECK: begin
                  if (w_bad) begin
                     if (SETTLE_CYC == 0) begin
                        r_state <= ST_FLAGGED;
                     end else begin
                        r_state  <= ST_PENDING;
                        r_settle <= 8'd1;
                     end
                  end
               end
               ST_PENDING: begin
                  if (!w_bad) begin
                     r_state  <= ST_CHECK;
                     r_settle <= '0;
                  end else if (r_settle == 8'(SETTLE_CYC)) begin
                     r_state  <= ST_FLAGGED;
                     r_settle <= '0;
                  end else begin
                     r_settle <= r_settle + 8'd1;
                  end
               end
               ST_FLAGGED: begin
                  if (!w_bad) r_state <= ST_CHECK;
               end
               default: r_state <= ST_IDLE;
            endcase
         end

         // clr wins over a same-cycle increment / capture.
         if (clr) begin
            viol_cnt    <= '0;
            err_sticky  <= 1'b0;
            first_valid <= 1'b0;
            first_type  <= '0;
            first_cpus  <= '0;
         end else if (w_flag) begin
            if (viol_cnt != '1) viol_cnt <= viol_cnt + CNT_W'(1);
            err_sticky <= 1'b1;
            if (!first_valid) begin
               first_valid <= 1'b1;
               first_type  <= w_class;
               first_cpus  <= w_noni_mask;
            end
         end
      end
   end

endmodule
`default_nettype wire
